// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Brings an asynchronous, already glitch-filtered level into the clk domain,
//   measures the width of each high pulse in clk cycles and offers each result
//   on a valid/ready output. Pulses shorter than MIN_WIDTH are discarded. A
//   result produced while the previous one is still unconsumed is dropped and
//   the sticky overrun flag is raised.
//
// Parameters
//   CNT_W       width of the width counter and of width_data
//   SYNC_STAGES synchronizer depth on signal_in (>= 2)
//   MIN_WIDTH   shortest accepted pulse in clk cycles
//
// Ports
//   clk          in   clock, all state on posedge
//   rst          in   asynchronous active-high reset
//   signal_in    in   filtered level, asynchronous to clk
//   enable       in   1 = measuring allowed, 0 = abort and disarm
//   overrun_clr  in   single-cycle pulse clearing overrun
//   width_ready  in   downstream accepts the held result
//   width_valid  out  a result is held on width_data/width_sat
//   width_data   out  measured high time in clk cycles (saturating)
//   width_sat    out  counter saturated during this pulse
//   overrun      out  sticky: a result was dropped because the output was full
module pulse_width_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_WIDTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signal_in,
  input  logic             enable,
  input  logic             overrun_clr,
  input  logic             width_ready,
  output logic             width_valid,
  output logic [CNT_W-1:0] width_data,
  output logic             width_sat,
  output logic             overrun
);

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_IDLE    = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_WIDTH);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_sync_vld;
  logic                   r_s_d;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sat;
  logic                   r_valid;
  logic [CNT_W-1:0]       r_data;
  logic                   r_data_sat;
  logic                   r_overrun;

  logic                   w_s;
  logic                   w_s_known;
  logic                   w_rise;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_cnt_start;
  logic                   w_cnt_step;
  logic                   w_publish;

  // Synchronizer. r_sync_vld marks when the last stage holds a real sample of
  // signal_in rather than its reset zero, so a level that is already high
  // across reset cannot look like a fresh low followed by a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync     <= '0;
      r_sync_vld <= '0;
      r_s_d      <= 1'b0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], signal_in};
      r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
      r_s_d      <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_s_known = r_sync_vld[SYNC_STAGES-1];
  assign w_rise    = w_s & ~r_s_d;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_ARM;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_start = 1'b0;
    w_cnt_step  = 1'b0;
    w_publish   = 1'b0;
    case (r_state)
      ST_ARM: begin
        if (enable && w_s_known && !w_s) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (!enable) begin
          w_state_nxt = ST_ARM;
        end else if (w_rise) begin
          w_state_nxt = ST_MEASURE;
          w_cnt_start = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          w_state_nxt = ST_ARM;
        end else if (w_s) begin
          w_cnt_step = 1'b1;
        end else begin
          // MEASURE is only entered on a rise, so s low here is the falling edge.
          w_state_nxt = ST_IDLE;
          w_publish   = (r_cnt >= CNT_MIN);
        end
      end
      default: w_state_nxt = ST_ARM;
    endcase
  end

  // Width counter: the rise cycle counts as 1, every further high cycle adds 1
  // until all-ones, and the saturation flag is raised on reaching all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_cnt_start) begin
      r_cnt <= CNT_ONE;
      r_sat <= (CNT_W == 1);
    end else if (w_cnt_step && (r_cnt != '1)) begin
      r_cnt <= w_cnt_inc;
      if (w_cnt_inc == '1) r_sat <= 1'b1;
    end
  end

  // Output holding register. A publish in the same cycle as a transfer
  // reloads the register so width_valid stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_data_sat <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_publish && (!r_valid || width_ready)) begin
        r_valid    <= 1'b1;
        r_data     <= r_cnt;
        r_data_sat <= r_sat;
      end else if (r_valid && width_ready) begin
        r_valid <= 1'b0;
      end

      if (w_publish && r_valid && !width_ready) r_overrun <= 1'b1;
      else if (overrun_clr)                     r_overrun <= 1'b0;
    end
  end

  assign width_valid = r_valid;
  assign width_data  = r_data;
  assign width_sat   = r_data_sat;
  assign overrun     = r_overrun;

endmodule
